// File: rtl/control_unit_pkg.sv
// Shared definitions for the multicycle control unit.
//
// Contents:
//   state_e     - FSM states (RST, FETCH, DECODE, MEM, WB, BR, HALT, ERR)
//   OP_*        - 4-bit opcode constants; wider opcodes are these zero-extended
//   PC_*        - pc_op encodings driven to the program counter
//   is_legal()  - true for any defined 4-bit opcode
//   is_alu()    - true for the ALU opcode range 3..7
package control_unit_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_BR     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_LOAD   = 4'd1;
  localparam logic [3:0] OP_STORE  = 4'd2;
  localparam logic [3:0] OP_ALU_LO = 4'd3;
  localparam logic [3:0] OP_ALU_HI = 4'd7;
  localparam logic [3:0] OP_LOADI  = 4'd8;
  localparam logic [3:0] OP_JMP    = 4'd9;
  localparam logic [3:0] OP_BRZ    = 4'd10;
  localparam logic [3:0] OP_HALT   = 4'd15;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;
  localparam logic [1:0] PC_CLR  = 2'b11;

  function automatic logic is_alu(input logic [3:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  endfunction

  // Opcodes 11..14 are unassigned; everything else in the 4-bit space is defined.
  function automatic logic is_legal(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    if (op == OP_NOP || op == OP_LOAD || op == OP_STORE || is_alu(op) ||
        op == OP_LOADI || op == OP_JMP || op == OP_BRZ || op == OP_HALT) begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state timer for the multicycle control unit.
//
// Counts cycles in which the controller is waiting on mem_ready and flags the
// cycle in which the wait budget is used up.
//
// Ports:
//   clock    in  - rising-edge clock
//   reset    in  - asynchronous active-low reset, clears the count
//   clear    in  - restart the count (asserted on every FSM state change)
//   wait_en  in  - this cycle is a wait cycle (access pending, mem_ready low)
//   expired  out - this wait cycle is the MEM_TIMEOUT-th one; low when MEM_TIMEOUT=0
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic wait_en,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  // Count value present during the last permitted wait cycle. The first wait
  // cycle sees a count of zero, so the MEM_TIMEOUT-th sees MEM_TIMEOUT-1.
  localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
  localparam logic TIMEOUT_ON = (MEM_TIMEOUT > 0);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise advance on wait cycles and saturate at
  // LAST so a disabled or already-expired timer never wraps.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (wait_en && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = TIMEOUT_ON && wait_en && (count_q == LAST);

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle control unit for the task CPU.
//
// Sequences FETCH -> DECODE -> (MEM / WB / BR) for each instruction and drives
// the datapath strobes as combinational decodes of the current state, the
// latched opcode, mem_ready and flag. Memory accesses wait on mem_ready and
// are bounded by a wait timer; a timeout or an illegal opcode (when
// ILLEGAL_HALT=1) parks the core in ERR until reset.
//
// Parameters:
//   OPW          - opcode width (>= 4); bits above bit 3 must be zero
//   MEM_TIMEOUT  - maximum wait cycles on mem_ready, 0 disables the timeout
//   ILLEGAL_HALT - 1: illegal opcode enters ERR, 0: it behaves as NOP
//
// Ports:
//   clock, reset (async active-low)
//   opcode     in  - instruction-register opcode, sampled in DECODE
//   flag       in  - ALU zero flag, sampled in BR for BRZ
//   mem_ready  in  - memory completes the current access this cycle
//   inst_wr    out - instruction-register load
//   decoder_en out - instruction decoder enable
//   reg_en     out - register-file enable
//   rD_wr      out - destination-register write
//   imm_en     out - writeback mux selects the immediate
//   mem_rd     out - memory read request
//   mem_wr     out - memory write request
//   adrs_ctrl  out - address mux, 0 = PC, 1 = operand address
//   pc_op      out - 00 hold, 01 increment, 10 load target, 11 clear
//   halted     out - core stopped (HALT or ERR)
//   bus_err    out - sticky timeout / illegal-opcode error
module control_unit_mc
  import control_unit_pkg::*;
#(
  parameter int OPW          = 4,
  parameter int MEM_TIMEOUT  = 15,
  parameter int ILLEGAL_HALT = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           flag,
  input  logic           mem_ready,
  output logic           inst_wr,
  output logic           decoder_en,
  output logic           reg_en,
  output logic           rD_wr,
  output logic           imm_en,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           adrs_ctrl,
  output logic [1:0]     pc_op,
  output logic           halted,
  output logic           bus_err
);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] op_q;
  logic [3:0] op_d;

  logic opLegal;
  logic timerClear;
  logic timerWait;
  logic timerExpired;

  // Only the low nibble carries a defined opcode; any set bit above it makes
  // the instruction illegal regardless of the low nibble.
  assign opLegal = ((opcode >> 4) == '0) && is_legal(opcode[3:0]);

  // The timer restarts whenever the FSM changes state and counts only while a
  // memory access is outstanding without completion.
  assign timerClear = (state_d != state_q);
  assign timerWait  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timerClear),
    .wait_en(timerWait),
    .expired(timerExpired)
  );

  // State and opcode registers. Reset forces RST immediately so any pending
  // memory request drops in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state and output decode. Everything defaults to idle; each state
  // raises only the strobes it owns. A mem_ready in the timeout cycle is
  // checked first so a late completion still succeeds.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    inst_wr    = 1'b0;
    decoder_en = 1'b0;
    reg_en     = 1'b0;
    rD_wr      = 1'b0;
    imm_en     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    adrs_ctrl  = 1'b0;
    pc_op      = PC_HOLD;
    halted     = 1'b0;
    bus_err    = 1'b0;

    case (state_q)
      ST_RST: begin
        pc_op   = PC_CLR;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        mem_rd    = 1'b1;
        adrs_ctrl = 1'b0;
        if (mem_ready) begin
          inst_wr = 1'b1;
          pc_op   = PC_INC;
          state_d = ST_DECODE;
        end else if (timerExpired) begin
          state_d = ST_ERR;
        end
      end

      ST_DECODE: begin
        decoder_en = 1'b1;
        reg_en     = 1'b1;
        op_d       = opcode[3:0];
        if (!opLegal) begin
          state_d = (ILLEGAL_HALT != 0) ? ST_ERR : ST_FETCH;
        end else if (opcode[3:0] == OP_LOAD || opcode[3:0] == OP_STORE) begin
          state_d = ST_MEM;
        end else if (is_alu(opcode[3:0]) || opcode[3:0] == OP_LOADI) begin
          state_d = ST_WB;
        end else if (opcode[3:0] == OP_JMP || opcode[3:0] == OP_BRZ) begin
          state_d = ST_BR;
        end else if (opcode[3:0] == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_MEM: begin
        adrs_ctrl = 1'b1;
        mem_rd    = (op_q == OP_LOAD);
        mem_wr    = (op_q == OP_STORE);
        if (mem_ready) begin
          state_d = (op_q == OP_LOAD) ? ST_WB : ST_FETCH;
        end else if (timerExpired) begin
          state_d = ST_ERR;
        end
      end

      ST_WB: begin
        rD_wr   = 1'b1;
        reg_en  = 1'b1;
        imm_en  = (op_q == OP_LOADI);
        state_d = ST_FETCH;
      end

      ST_BR: begin
        if ((op_q == OP_JMP) || ((op_q == OP_BRZ) && flag)) begin
          pc_op = PC_LOAD;
        end
        state_d = ST_FETCH;
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      ST_ERR: begin
        halted  = 1'b1;
        bus_err = 1'b1;
      end

      default: begin
        state_d = ST_ERR;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit_mc.sv
// Scoreboard testbench for control_unit_mc.
//
// Three instances share one set of inputs:
//   dut0 - OPW=4, MEM_TIMEOUT=15, ILLEGAL_HALT=1 (defaults)
//   dut1 - OPW=6, MEM_TIMEOUT=4,  ILLEGAL_HALT=1
//   dut2 - OPW=6, MEM_TIMEOUT=0,  ILLEGAL_HALT=0
// Each directed vector drives the inputs for one cycle and queues the
// hand-computed output word for the selected instance; a monitor pops and
// compares on the falling edge of that cycle.
module tb_control_unit_mc;

  // Output word layout:
  // [11] inst_wr [10] decoder_en [9] reg_en [8] rD_wr [7] imm_en [6] mem_rd
  // [5] mem_wr [4] adrs_ctrl [3:2] pc_op [1] halted [0] bus_err
  localparam logic [11:0] X_RST   = 12'b0000_0000_1100;
  localparam logic [11:0] X_FWAIT = 12'b0000_0100_0000;
  localparam logic [11:0] X_FDONE = 12'b1000_0100_0100;
  localparam logic [11:0] X_DEC   = 12'b0110_0000_0000;
  localparam logic [11:0] X_MLD   = 12'b0000_0101_0000;
  localparam logic [11:0] X_MST   = 12'b0000_0011_0000;
  localparam logic [11:0] X_WB    = 12'b0011_0000_0000;
  localparam logic [11:0] X_WBI   = 12'b0011_1000_0000;
  localparam logic [11:0] X_BRL   = 12'b0000_0000_1000;
  localparam logic [11:0] X_BRH   = 12'b0000_0000_0000;
  localparam logic [11:0] X_HALT  = 12'b0000_0000_0010;
  localparam logic [11:0] X_ERR   = 12'b0000_0000_0011;

  typedef struct {
    int          dut;
    logic [11:0] exp;
    string       tag;
  } sbItem_t;

  logic       clock;
  logic       reset;
  logic [5:0] opcode;
  logic       flag;
  logic       mem_ready;

  wire [11:0] act0;
  wire [11:0] act1;
  wire [11:0] act2;

  sbItem_t sbq[$];
  int vecCount;
  int missCount;

  control_unit_mc #(.OPW(4), .MEM_TIMEOUT(15), .ILLEGAL_HALT(1)) dut0 (
    .clock(clock), .reset(reset), .opcode(opcode[3:0]), .flag(flag), .mem_ready(mem_ready),
    .inst_wr(act0[11]), .decoder_en(act0[10]), .reg_en(act0[9]), .rD_wr(act0[8]),
    .imm_en(act0[7]), .mem_rd(act0[6]), .mem_wr(act0[5]), .adrs_ctrl(act0[4]),
    .pc_op(act0[3:2]), .halted(act0[1]), .bus_err(act0[0])
  );

  control_unit_mc #(.OPW(6), .MEM_TIMEOUT(4), .ILLEGAL_HALT(1)) dut1 (
    .clock(clock), .reset(reset), .opcode(opcode), .flag(flag), .mem_ready(mem_ready),
    .inst_wr(act1[11]), .decoder_en(act1[10]), .reg_en(act1[9]), .rD_wr(act1[8]),
    .imm_en(act1[7]), .mem_rd(act1[6]), .mem_wr(act1[5]), .adrs_ctrl(act1[4]),
    .pc_op(act1[3:2]), .halted(act1[1]), .bus_err(act1[0])
  );

  control_unit_mc #(.OPW(6), .MEM_TIMEOUT(0), .ILLEGAL_HALT(0)) dut2 (
    .clock(clock), .reset(reset), .opcode(opcode), .flag(flag), .mem_ready(mem_ready),
    .inst_wr(act2[11]), .decoder_en(act2[10]), .reg_en(act2[9]), .rD_wr(act2[8]),
    .imm_en(act2[7]), .mem_rd(act2[6]), .mem_wr(act2[5]), .adrs_ctrl(act2[4]),
    .pc_op(act2[3:2]), .halted(act2[1]), .bus_err(act2[0])
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one cycle of inputs just after the rising edge and queue the
  // output word expected for that same cycle.
  task automatic applyStimulus(input int dut, input logic rn, input logic [5:0] op,
                               input logic fl, input logic rdy,
                               input logic [11:0] exp, input string tag);
    sbItem_t it;
    @(posedge clock);
    #1;
    reset     = rn;
    opcode    = op;
    flag      = fl;
    mem_ready = rdy;
    it.dut = dut;
    it.exp = exp;
    it.tag = tag;
    sbq.push_back(it);
  endtask

  // Reset held for one cycle, then released; RST drives pc_op=11 in both.
  task automatic resetDut(input int dut);
    applyStimulus(dut, 1'b0, 6'd0, 1'b0, 1'b0, X_RST, "reset_hold");
    applyStimulus(dut, 1'b1, 6'd0, 1'b0, 1'b0, X_RST, "reset_release");
  endtask

  task automatic checkOutput(input sbItem_t it);
    logic [11:0] act;
    act = (it.dut == 0) ? act0 : ((it.dut == 1) ? act1 : act2);
    vecCount++;
    if (act !== it.exp) begin
      missCount++;
      $display("[TB] FAIL %s: dut%0d outputs %b, expected %b at %0t",
               it.tag, it.dut, act, it.exp, $time);
    end
  endtask

  // Monitor: compare whenever a vector is outstanding for this cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (sbq.size() != 0) begin
        checkOutput(sbq.pop_front());
      end
    end
  end

  initial begin
    vecCount  = 0;
    missCount = 0;
    reset     = 1'b0;
    opcode    = 6'd0;
    flag      = 1'b0;
    mem_ready = 1'b0;

    // NOP, ALU, HALT with zero wait states.
    resetDut(0);
    applyStimulus(0, 1, 6'd0,  0, 1, X_FDONE, "nop_fetch");
    applyStimulus(0, 1, 6'd0,  0, 1, X_DEC,   "nop_decode");
    applyStimulus(0, 1, 6'd3,  0, 1, X_FDONE, "alu_fetch");
    applyStimulus(0, 1, 6'd3,  0, 1, X_DEC,   "alu_decode");
    applyStimulus(0, 1, 6'd3,  0, 1, X_WB,    "alu_wb");
    applyStimulus(0, 1, 6'd15, 0, 1, X_FDONE, "halt_fetch");
    applyStimulus(0, 1, 6'd15, 0, 1, X_DEC,   "halt_decode");
    applyStimulus(0, 1, 6'd15, 0, 1, X_HALT,  "halted");
    applyStimulus(0, 1, 6'd0,  1, 1, X_HALT,  "halt_sticky");

    // LOAD with three MEM wait states; opcode changes after DECODE are ignored.
    resetDut(0);
    applyStimulus(0, 1, 6'd1, 0, 1, X_FDONE, "load_fetch");
    applyStimulus(0, 1, 6'd1, 0, 1, X_DEC,   "load_decode");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 6'd8, 0, 0, X_MLD, "load_mem_wait");
    applyStimulus(0, 1, 6'd8, 0, 1, X_MLD,   "load_mem_done");
    applyStimulus(0, 1, 6'd8, 0, 0, X_WB,    "load_wb");
    applyStimulus(0, 1, 6'd8, 0, 0, X_FWAIT, "loadi_fetch_wait");
    applyStimulus(0, 1, 6'd8, 0, 1, X_FDONE, "loadi_fetch");
    applyStimulus(0, 1, 6'd8, 0, 1, X_DEC,   "loadi_decode");
    applyStimulus(0, 1, 6'd8, 0, 1, X_WBI,   "loadi_wb");
    applyStimulus(0, 1, 6'd2, 0, 1, X_FDONE, "store_fetch");
    applyStimulus(0, 1, 6'd2, 0, 1, X_DEC,   "store_decode");
    applyStimulus(0, 1, 6'd2, 0, 0, X_MST,   "store_mem_wait");
    applyStimulus(0, 1, 6'd2, 0, 1, X_MST,   "store_mem_done");
    // BRZ taken, BRZ not taken (flag high only outside BR), JMP.
    applyStimulus(0, 1, 6'd10, 0, 1, X_FDONE, "brz1_fetch");
    applyStimulus(0, 1, 6'd10, 0, 1, X_DEC,   "brz1_decode");
    applyStimulus(0, 1, 6'd10, 1, 1, X_BRL,   "brz_taken");
    applyStimulus(0, 1, 6'd10, 1, 1, X_FDONE, "brz2_fetch");
    applyStimulus(0, 1, 6'd10, 1, 1, X_DEC,   "brz2_decode");
    applyStimulus(0, 1, 6'd10, 0, 1, X_BRH,   "brz_not_taken");
    applyStimulus(0, 1, 6'd9,  0, 1, X_FDONE, "jmp_fetch");
    applyStimulus(0, 1, 6'd9,  0, 1, X_DEC,   "jmp_decode");
    applyStimulus(0, 1, 6'd9,  0, 1, X_BRL,   "jmp_taken");
    // Unassigned 4-bit opcode on the default instance.
    applyStimulus(0, 1, 6'd11, 0, 1, X_FDONE, "illegal_fetch");
    applyStimulus(0, 1, 6'd11, 0, 1, X_DEC,   "illegal_decode");
    applyStimulus(0, 1, 6'd0,  0, 1, X_ERR,   "illegal_err");
    applyStimulus(0, 1, 6'd0,  0, 0, X_ERR,   "illegal_err_sticky");

    // Fetch timeout after four waits, sticky error.
    resetDut(1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 6'd0, 0, 0, X_FWAIT, "fetch_to_wait");
    applyStimulus(1, 1, 6'd0, 0, 0, X_ERR, "fetch_timeout_err");
    applyStimulus(1, 1, 6'd0, 0, 1, X_ERR, "fetch_timeout_sticky");

    // mem_ready on the fourth wait cycle wins; then a wide illegal opcode.
    resetDut(1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 6'd0, 0, 0, X_FWAIT, "limit_wait");
    applyStimulus(1, 1, 6'd0,       0, 1, X_FDONE, "ready_at_limit");
    applyStimulus(1, 1, 6'b010001, 0, 1, X_DEC,   "wide_illegal_decode");
    applyStimulus(1, 1, 6'd0,       0, 1, X_ERR,   "wide_illegal_err");

    // Timer restarts on entry to MEM; then a STORE that times out in MEM.
    resetDut(1);
    for (int i = 0; i < 2; i++) applyStimulus(1, 1, 6'd1, 0, 0, X_FWAIT, "pre_load_wait");
    applyStimulus(1, 1, 6'd1, 0, 1, X_FDONE, "wide_load_fetch");
    applyStimulus(1, 1, 6'd1, 0, 1, X_DEC,   "wide_load_decode");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 6'd1, 0, 0, X_MLD, "mem_timer_restart");
    applyStimulus(1, 1, 6'd1, 0, 1, X_MLD,   "wide_load_mem_done");
    applyStimulus(1, 1, 6'd2, 0, 1, X_WB,    "wide_load_wb");
    applyStimulus(1, 1, 6'd2, 0, 1, X_FDONE, "wide_store_fetch");
    applyStimulus(1, 1, 6'd2, 0, 1, X_DEC,   "wide_store_decode");
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 6'd2, 0, 0, X_MST, "store_to_wait");
    applyStimulus(1, 1, 6'd2, 0, 0, X_ERR,   "mem_timeout_err");

    // Illegal wide opcode as NOP, and no timeout with MEM_TIMEOUT=0.
    resetDut(2);
    applyStimulus(2, 1, 6'b010001, 0, 1, X_FDONE, "nop_illegal_fetch");
    applyStimulus(2, 1, 6'b010001, 0, 1, X_DEC,   "nop_illegal_decode");
    for (int i = 0; i < 16; i++) applyStimulus(2, 1, 6'd0, 0, 0, X_FWAIT, "no_timeout_wait");
    applyStimulus(2, 1, 6'd0, 0, 1, X_FDONE, "late_fetch_done");

    // Reset during the MEM cycle of a STORE.
    resetDut(0);
    applyStimulus(0, 1, 6'd2, 0, 1, X_FDONE, "rst_store_fetch");
    applyStimulus(0, 1, 6'd2, 0, 1, X_DEC,   "rst_store_decode");
    applyStimulus(0, 1, 6'd2, 0, 0, X_MST,   "rst_store_mem");
    applyStimulus(0, 0, 6'd2, 0, 0, X_RST,   "reset_mid_store");
    applyStimulus(0, 1, 6'd2, 0, 1, X_RST,   "reset_mid_release");
    applyStimulus(0, 1, 6'd0, 0, 1, X_FDONE, "restart_fetch");

    @(negedge clock);
    #1;
    if (sbq.size() != 0) begin
      missCount++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
